// File: rtl/shift_rs_pkg.sv
// shift_rs_pkg: shared constants and the reservation-station entry layout.
// The entry struct fixes the tag width at RS_TAGW.
package shift_rs_pkg;

   localparam int RS_TAGW  = 4;
   localparam int RS_DEPTH = 4;

   typedef struct packed {
      logic                    valid;
      logic [7:0]              operand;
      logic [1:0]              rdy;
      logic [1:0][RS_TAGW-1:0] tag;
      logic [1:0][7:0]         val;
      logic [7:0]              wbs;
      logic [7:0]              flags;
      logic [RS_TAGW-1:0]      robid;
   } shift_rs_entry_t;

endpackage

// File: rtl/shift_rs_select.sv
// shift_rs_select: picks one issuable entry. With SHIFT_RS_OLDEST_FIRST_EN defined
// the entry with the largest age wins; otherwise the lowest index wins.
module shift_rs_select
   import shift_rs_pkg::*;
#(
   parameter int DEPTH = RS_DEPTH
) (
   input  logic [DEPTH-1:0]                      issuable,
`ifdef SHIFT_RS_OLDEST_FIRST_EN
   input  logic [DEPTH-1:0][$clog2(DEPTH)-1:0]   ages,
`endif
   output logic                                  sel_valid,
   output logic [DEPTH-1:0]                      sel_onehot,
   output logic [$clog2(DEPTH)-1:0]              sel_idx
);

   localparam int IW = $clog2(DEPTH);

`ifdef SHIFT_RS_OLDEST_FIRST_EN
   logic [IW-1:0] best_age;

   // Ages are unique among valid entries, so a strict compare never ties.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      best_age  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (issuable[i] && (!sel_valid || ages[i] > best_age)) begin
            sel_valid = 1'b1;
            sel_idx   = IW'(i);
            best_age  = ages[i];
         end
      end
      sel_onehot = sel_valid ? (DEPTH'(1) << sel_idx) : '0;
   end
`else
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (issuable[i]) begin
            sel_valid = 1'b1;
            sel_idx   = IW'(i);
         end
      end
      sel_onehot = sel_valid ? (DEPTH'(1) << sel_idx) : '0;
   end
`endif

endmodule

// File: rtl/shift_rs.sv
// shift_rs: reservation station feeding the shift FU, with CDB snoop and dispatch bypass.
// Define SHIFT_RS_OLDEST_FIRST_EN for oldest-first issue instead of lowest-index.
module shift_rs
   import shift_rs_pkg::*;
#(
   parameter int DEPTH = RS_DEPTH,
   parameter int TAGW  = RS_TAGW
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        dispatch_valid,
   input  logic [7:0]                  dispatch_operand,
   input  logic [1:0]                  dispatch_ready,
   input  logic [1:0][TAGW-1:0]        dispatch_tags,
   input  logic [1:0][7:0]             dispatch_vals,
   input  logic [7:0]                  dispatch_wbs,
   input  logic [7:0]                  dispatch_flags,
   input  logic [TAGW-1:0]             dispatch_robid,
   output logic                        full,
   output logic [$clog2(DEPTH+1)-1:0]  occupancy,
   input  logic                        cdb_valid,
   input  logic [TAGW-1:0]             cdb_id,
   input  logic [7:0]                  cdb_val,
   input  logic                        fu_busy,
   output logic                        issue_transmit,
   output logic [7:0]                  issue_operand,
   output logic [1:0][7:0]             issue_depvals,
   output logic [7:0]                  issue_wbs,
   output logic [7:0]                  issue_flags,
   output logic [TAGW-1:0]             issue_robid
);

   localparam int IW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);

   shift_rs_entry_t   ents [DEPTH];
   shift_rs_entry_t   new_ent;
   logic [DEPTH-1:0]  valid;
   logic [DEPTH-1:0]  issuable;
   logic [DEPTH-1:0]  sel_onehot;
   logic              sel_valid;
   logic [IW-1:0]     sel_idx;
   logic [IW-1:0]     free_idx;
   logic [OW-1:0]     count;
   logic              accept;
   logic              issue_go;

   // Status is derived from registered valid bits only.
   always_comb begin
      valid    = '0;
      issuable = '0;
      count    = '0;
      free_idx = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         valid[i]    = ents[i].valid;
         issuable[i] = ents[i].valid && (ents[i].rdy == 2'b11);
         count       = count + OW'(ents[i].valid);
         if (!ents[i].valid) free_idx = IW'(i);
      end
   end

   assign full      = &valid;
   assign occupancy = count;
   assign accept    = dispatch_valid && !full;
   assign issue_go  = sel_valid && !fu_busy;

   // Incoming entry, with same-cycle CDB capture for sources still waiting.
   always_comb begin
      new_ent.valid   = 1'b1;
      new_ent.operand = dispatch_operand;
      new_ent.wbs     = dispatch_wbs;
      new_ent.flags   = dispatch_flags;
      new_ent.robid   = dispatch_robid;
      new_ent.rdy     = dispatch_ready;
      new_ent.tag     = dispatch_tags;
      new_ent.val     = dispatch_vals;
      for (int s = 0; s < 2; s++) begin
         if (!dispatch_ready[s] && cdb_valid && dispatch_tags[s] == cdb_id) begin
            new_ent.rdy[s] = 1'b1;
            new_ent.val[s] = cdb_val;
         end
      end
   end

`ifdef SHIFT_RS_OLDEST_FIRST_EN
   logic [DEPTH-1:0][IW-1:0] ages;

   shift_rs_select #(.DEPTH(DEPTH)) u_select (
      .issuable   (issuable),
      .ages       (ages),
      .sel_valid  (sel_valid),
      .sel_onehot (sel_onehot),
      .sel_idx    (sel_idx)
   );

   // Age = number of younger valid entries; entries older than the issued one
   // step down so ages stay unique and never exceed DEPTH-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         ages <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (accept && free_idx == IW'(i))
               ages[i] <= '0;
            else if (ents[i].valid)
               ages[i] <= ages[i] + IW'(accept) - IW'(issue_go && (ages[i] > ages[sel_idx]));
         end
      end
   end
`else
   shift_rs_select #(.DEPTH(DEPTH)) u_select (
      .issuable   (issuable),
      .sel_valid  (sel_valid),
      .sel_onehot (sel_onehot),
      .sel_idx    (sel_idx)
   );
`endif

   // Entry storage: only the valid bits are reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ents[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (accept && free_idx == IW'(i)) begin
               ents[i] <= new_ent;
            end else if (ents[i].valid) begin
               for (int s = 0; s < 2; s++) begin
                  if (!ents[i].rdy[s] && cdb_valid && ents[i].tag[s] == cdb_id) begin
                     ents[i].rdy[s] <= 1'b1;
                     ents[i].val[s] <= cdb_val;
                  end
               end
            end
            if (issue_go && sel_onehot[i]) ents[i].valid <= 1'b0;
         end
      end
   end

   // Issue register stage toward the FU.
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_transmit <= 1'b0;
         issue_operand  <= '0;
         issue_depvals  <= '0;
         issue_wbs      <= '0;
         issue_flags    <= '0;
         issue_robid    <= '0;
      end else begin
         issue_transmit <= issue_go;
         if (issue_go) begin
            issue_operand <= ents[sel_idx].operand;
            issue_depvals <= ents[sel_idx].val;
            issue_wbs     <= ents[sel_idx].wbs;
            issue_flags   <= ents[sel_idx].flags;
            issue_robid   <= ents[sel_idx].robid;
         end
      end
   end

endmodule

// File: tb/tb_shift_rs.sv
// tb_shift_rs: directed scenarios plus randomized traffic checked against a
// slot-array model that orders entries by dispatch sequence number.
module tb_shift_rs;

   localparam int DEPTH = 4;
   localparam int TAGW  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              dispatch_valid;
   logic [7:0]        dispatch_operand;
   logic [1:0]        dispatch_ready;
   logic [1:0][3:0]   dispatch_tags;
   logic [1:0][7:0]   dispatch_vals;
   logic [7:0]        dispatch_wbs;
   logic [7:0]        dispatch_flags;
   logic [3:0]        dispatch_robid;
   logic              full;
   logic [2:0]        occupancy;
   logic              cdb_valid;
   logic [3:0]        cdb_id;
   logic [7:0]        cdb_val;
   logic              fu_busy;
   logic              issue_transmit;
   logic [7:0]        issue_operand;
   logic [1:0][7:0]   issue_depvals;
   logic [7:0]        issue_wbs;
   logic [7:0]        issue_flags;
   logic [3:0]        issue_robid;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   shift_rs #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
      .clk(clk), .rst(rst),
      .dispatch_valid(dispatch_valid), .dispatch_operand(dispatch_operand),
      .dispatch_ready(dispatch_ready), .dispatch_tags(dispatch_tags),
      .dispatch_vals(dispatch_vals), .dispatch_wbs(dispatch_wbs),
      .dispatch_flags(dispatch_flags), .dispatch_robid(dispatch_robid),
      .full(full), .occupancy(occupancy),
      .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
      .fu_busy(fu_busy),
      .issue_transmit(issue_transmit), .issue_operand(issue_operand),
      .issue_depvals(issue_depvals), .issue_wbs(issue_wbs),
      .issue_flags(issue_flags), .issue_robid(issue_robid)
   );

   typedef struct packed {
      bit              v;
      bit [7:0]        op;
      bit [1:0]        rdy;
      bit [1:0][3:0]   tag;
      bit [1:0][7:0]   val;
      bit [7:0]        wbs;
      bit [7:0]        flags;
      bit [3:0]        robid;
      int unsigned     seq;
   } m_ent_t;

   m_ent_t          m [DEPTH];
   int unsigned     seq_ctr;
   bit              exp_tx;
   bit [7:0]        exp_op, exp_wbs, exp_flags;
   bit [1:0][7:0]   exp_vals;
   bit [3:0]        exp_robid;
   int              exp_occ;
   bit              exp_full;

   // Model of one clock edge: issue oldest/lowest ready slot, snoop, then insert.
   function automatic void model_step();
      int n, free, pick;
      bit go, acc;
      m_ent_t e;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
         exp_tx = 0; exp_op = 0; exp_wbs = 0; exp_flags = 0; exp_vals = 0; exp_robid = 0;
         seq_ctr = 0;
      end else begin
         n = 0; free = -1; pick = -1;
         for (int i = 0; i < DEPTH; i++) begin
            if (m[i].v) n++;
            else if (free < 0) free = i;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (m[i].v && m[i].rdy == 2'b11) begin
`ifdef SHIFT_RS_OLDEST_FIRST_EN
               if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
               if (pick < 0) pick = i;
`endif
            end
         end
         go  = (pick >= 0) && !fu_busy;
         acc = dispatch_valid && (n < DEPTH);
         exp_tx = go;
         if (go) begin
            exp_op = m[pick].op; exp_vals = m[pick].val; exp_wbs = m[pick].wbs;
            exp_flags = m[pick].flags; exp_robid = m[pick].robid;
            m[pick].v = 1'b0;
         end
         for (int i = 0; i < DEPTH; i++)
            for (int s = 0; s < 2; s++)
               if (m[i].v && !m[i].rdy[s] && cdb_valid && m[i].tag[s] == cdb_id) begin
                  m[i].rdy[s] = 1'b1; m[i].val[s] = cdb_val;
               end
         if (acc) begin
            e.v = 1; e.op = dispatch_operand; e.rdy = dispatch_ready; e.tag = dispatch_tags;
            e.val = dispatch_vals; e.wbs = dispatch_wbs; e.flags = dispatch_flags;
            e.robid = dispatch_robid; e.seq = seq_ctr++;
            for (int s = 0; s < 2; s++)
               if (!e.rdy[s] && cdb_valid && e.tag[s] == cdb_id) begin
                  e.rdy[s] = 1'b1; e.val[s] = cdb_val;
               end
            m[free] = e;
         end
      end
      n = 0;
      for (int i = 0; i < DEPTH; i++) if (m[i].v) n++;
      exp_occ  = n;
      exp_full = (n == DEPTH);
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      dispatch_valid = 0; cdb_valid = 0; fu_busy = 0;
   endtask

   task automatic set_disp(input logic [7:0] op, input logic [1:0] rdy, input logic [3:0] t1,
                           input logic [3:0] t0, input logic [7:0] v1, input logic [7:0] v0,
                           input logic [3:0] rid);
      dispatch_valid = 1; dispatch_operand = op; dispatch_ready = rdy;
      dispatch_tags[1] = t1; dispatch_tags[0] = t0;
      dispatch_vals[1] = v1; dispatch_vals[0] = v0;
      dispatch_wbs = op ^ 8'h5A; dispatch_flags = ~op; dispatch_robid = rid;
   endtask

   task automatic test_reset();
      rst = 1; idle(); set_disp(8'h00, 2'b00, 0, 0, 0, 0, 0); dispatch_valid = 0;
      cdb_id = 0; cdb_val = 0;
      cycle(); cycle();
      n_tests++; if (issue_transmit !== 1'b0) begin n_fail++; $display("FAIL reset_tx got=%0b want=0", issue_transmit); end
      n_tests++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
      n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%0b want=0", full); end
      n_tests++; if (issue_depvals !== 16'h0 || issue_robid !== 4'h0 || issue_operand !== 8'h0)
         begin n_fail++; $display("FAIL reset_data got=%h/%h/%h want=0", issue_depvals, issue_robid, issue_operand); end
      rst = 0;
   endtask

   task automatic test_ready_dispatch();
      set_disp(8'h00, 2'b11, 0, 0, 8'h03, 8'h02, 4'd5);
      cycle(); idle();
      n_tests++; if (issue_transmit !== 1'b0 || occupancy !== 3'd1) begin n_fail++; $display("FAIL rdy_accept tx=%0b occ=%0d want tx=0 occ=1", issue_transmit, occupancy); end
      cycle();
      n_tests++; if (issue_transmit !== 1'b1) begin n_fail++; $display("FAIL rdy_issue_tx got=%0b want=1", issue_transmit); end
      n_tests++; if (issue_depvals !== {8'h03, 8'h02} || issue_robid !== 4'd5) begin n_fail++; $display("FAIL rdy_issue_data got=%h rob=%0d want=0302 rob=5", issue_depvals, issue_robid); end
      n_tests++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rdy_occ got=%0d want=0", occupancy); end
      cycle();
      n_tests++; if (issue_transmit !== 1'b0) begin n_fail++; $display("FAIL rdy_pulse got=%0b want=0", issue_transmit); end
   endtask

   task automatic test_cdb_wakeup();
      set_disp(8'h11, 2'b10, 0, 4'd7, 8'h10, 8'h00, 4'd6);
      cycle(); idle(); cycle();
      cdb_valid = 1; cdb_id = 4'd7; cdb_val = 8'h04;
      cycle(); idle();
      n_tests++; if (issue_transmit !== 1'b0) begin n_fail++; $display("FAIL wake_early got=%0b want=0", issue_transmit); end
      cycle();
      n_tests++; if (issue_transmit !== 1'b1 || issue_depvals !== {8'h10, 8'h04} || issue_robid !== 4'd6)
         begin n_fail++; $display("FAIL wake_issue tx=%0b vals=%h rob=%0d want 1/1004/6", issue_transmit, issue_depvals, issue_robid); end
   endtask

   task automatic test_bypass();
      set_disp(8'h22, 2'b01, 4'd3, 0, 8'h00, 8'h01, 4'd7);
      cdb_valid = 1; cdb_id = 4'd3; cdb_val = 8'hA5;
      cycle(); idle();
      n_tests++; if (issue_transmit !== 1'b0 || occupancy !== 3'd1) begin n_fail++; $display("FAIL byp_accept tx=%0b occ=%0d want 0/1", issue_transmit, occupancy); end
      cycle();
      n_tests++; if (issue_transmit !== 1'b1 || issue_depvals !== {8'hA5, 8'h01} || issue_operand !== 8'h22)
         begin n_fail++; $display("FAIL byp_issue tx=%0b vals=%h op=%h want 1/A501/22", issue_transmit, issue_depvals, issue_operand); end
   endtask

   task automatic test_full();
      for (int i = 0; i < DEPTH; i++) begin
         set_disp(8'h40 + 8'(i), 2'b01, 4'(8 + i), 0, 8'h00, 8'(i), 4'(8 + i));
         cycle();
      end
      n_tests++; if (full !== 1'b1 || occupancy !== 3'd4) begin n_fail++; $display("FAIL full_set full=%0b occ=%0d want 1/4", full, occupancy); end
      set_disp(8'h7F, 2'b11, 0, 0, 8'hEE, 8'hEE, 4'd15);
      cycle(); idle();
      n_tests++; if (occupancy !== 3'd4 || issue_transmit !== 1'b0) begin n_fail++; $display("FAIL full_drop occ=%0d tx=%0b want 4/0", occupancy, issue_transmit); end
      cdb_valid = 1; cdb_id = 4'd10; cdb_val = 8'h22;
      cycle(); idle();
      n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_hold got=%0b want=1", full); end
      cycle();
      n_tests++; if (issue_transmit !== 1'b1 || issue_robid !== 4'd10 || issue_depvals !== {8'h22, 8'h02})
         begin n_fail++; $display("FAIL full_issue tx=%0b rob=%0d vals=%h want 1/10/2202", issue_transmit, issue_robid, issue_depvals); end
      n_tests++; if (full !== 1'b0 || occupancy !== 3'd3) begin n_fail++; $display("FAIL full_clear full=%0b occ=%0d want 0/3", full, occupancy); end
      foreach (dispatch_tags[k]) dispatch_tags[k] = 0;
      for (int t = 8; t < 12; t++) begin
         if (t != 10) begin cdb_valid = 1; cdb_id = 4'(t); cdb_val = 8'(t); cycle(); end
      end
      idle(); cycle(); cycle();
      n_tests++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL full_drain occ=%0d want=0", occupancy); end
   endtask

   task automatic test_busy();
      fu_busy = 1;
      set_disp(8'h31, 2'b11, 0, 0, 8'h01, 8'h01, 4'd1); cycle();
      set_disp(8'h32, 2'b11, 0, 0, 8'h02, 8'h02, 4'd2); cycle();
      dispatch_valid = 0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         n_tests++; if (issue_transmit !== 1'b0 || occupancy !== 3'd2) begin n_fail++; $display("FAIL busy_hold c=%0d tx=%0b occ=%0d want 0/2", c, issue_transmit, occupancy); end
      end
      fu_busy = 0;
      cycle();
      n_tests++; if (issue_transmit !== 1'b1 || issue_robid !== 4'd1) begin n_fail++; $display("FAIL busy_rel1 tx=%0b rob=%0d want 1/1", issue_transmit, issue_robid); end
      cycle();
      n_tests++; if (issue_transmit !== 1'b1 || issue_robid !== 4'd2) begin n_fail++; $display("FAIL busy_rel2 tx=%0b rob=%0d want 1/2", issue_transmit, issue_robid); end
      cycle();
      n_tests++; if (issue_transmit !== 1'b0 || issue_robid !== 4'd2) begin n_fail++; $display("FAIL busy_after tx=%0b rob=%0d want 0/2", issue_transmit, issue_robid); end
   endtask

   task automatic test_order();
      logic [3:0] first, second;
`ifdef SHIFT_RS_OLDEST_FIRST_EN
      first = 4'd2; second = 4'd3;
`else
      first = 4'd3; second = 4'd2;
`endif
      fu_busy = 1;
      set_disp(8'h51, 2'b11, 0, 0, 8'h11, 8'h11, 4'd1); cycle();
      set_disp(8'h52, 2'b10, 0, 4'd9, 8'h20, 8'h00, 4'd2); cycle();
      idle(); cycle();
      n_tests++; if (issue_transmit !== 1'b1 || issue_robid !== 4'd1) begin n_fail++; $display("FAIL order_a tx=%0b rob=%0d want 1/1", issue_transmit, issue_robid); end
      set_disp(8'h53, 2'b10, 0, 4'd9, 8'h30, 8'h00, 4'd3); cycle();
      idle(); cdb_valid = 1; cdb_id = 4'd9; cdb_val = 8'h44; cycle();
      idle(); cycle();
      n_tests++; if (issue_transmit !== 1'b1 || issue_robid !== first) begin n_fail++; $display("FAIL order_first tx=%0b rob=%0d want 1/%0d", issue_transmit, issue_robid, first); end
      cycle();
      n_tests++; if (issue_transmit !== 1'b1 || issue_robid !== second) begin n_fail++; $display("FAIL order_second tx=%0b rob=%0d want 1/%0d", issue_transmit, issue_robid, second); end
   endtask

   task automatic test_reset_mid();
      fu_busy = 1;
      set_disp(8'h61, 2'b11, 0, 0, 8'h61, 8'h61, 4'd4); cycle();
      set_disp(8'h62, 2'b11, 0, 0, 8'h62, 8'h62, 4'd5); cycle();
      idle(); rst = 1; cycle(); rst = 0;
      n_tests++; if (issue_transmit !== 1'b0 || occupancy !== 3'd0 || issue_robid !== 4'd0)
         begin n_fail++; $display("FAIL rstmid_cycle tx=%0b occ=%0d rob=%0d want 0/0/0", issue_transmit, occupancy, issue_robid); end
      cycle();
      n_tests++; if (issue_transmit !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL rstmid_after tx=%0b occ=%0d want 0/0", issue_transmit, occupancy); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         dispatch_valid = ($urandom_range(0, 2) != 0);
         dispatch_operand = 8'($urandom); dispatch_ready = 2'($urandom_range(0, 3));
         dispatch_tags[1] = 4'($urandom_range(0, 7)); dispatch_tags[0] = 4'($urandom_range(0, 7));
         dispatch_vals[1] = 8'($urandom); dispatch_vals[0] = 8'($urandom);
         dispatch_wbs = 8'($urandom); dispatch_flags = 8'($urandom); dispatch_robid = 4'($urandom);
         cdb_valid = ($urandom_range(0, 1) == 1); cdb_id = 4'($urandom_range(0, 7)); cdb_val = 8'($urandom);
         fu_busy = ($urandom_range(0, 3) == 0);
         cycle();
         n_tests++;
         if (issue_transmit !== exp_tx || issue_operand !== exp_op || issue_depvals !== exp_vals ||
             issue_wbs !== exp_wbs || issue_flags !== exp_flags || issue_robid !== exp_robid) begin
            n_fail++;
            $display("FAIL rand_issue c=%0d got tx=%0b op=%h v=%h w=%h f=%h r=%h want tx=%0b op=%h v=%h w=%h f=%h r=%h",
                     c, issue_transmit, issue_operand, issue_depvals, issue_wbs, issue_flags, issue_robid,
                     exp_tx, exp_op, exp_vals, exp_wbs, exp_flags, exp_robid);
         end
         n_tests++;
         if (occupancy !== 3'(exp_occ) || full !== exp_full) begin
            n_fail++; $display("FAIL rand_status c=%0d occ=%0d full=%0b want %0d/%0b", c, occupancy, full, exp_occ, exp_full);
         end
      end
      rst = 0; idle();
   endtask

   initial begin
      test_reset();
      test_ready_dispatch();
      test_cdb_wakeup();
      test_bypass();
      test_full();
      test_busy();
      test_order();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
